// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: shares one memory-bus port between the IFU and the LSU.
// Requests are forwarded combinationally. The grant is locked while the bus
// stalls. The LSU has priority, and a starvation timer bounds how long the IFU
// can wait. A small in-order owner FIFO steers each read response back to the
// unit that issued the read.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_FREE      | no lock, grant decided by priority/starvation each cycle
// ST_HOLD_IFU  | IFU request stalled on the bus, grant pinned to IFU
// ST_HOLD_LSU  | LSU request stalled on the bus, grant pinned to LSU
module core_bus_arbiter #(
    parameter int OUTST_DEPTH  = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_vld,
    output logic        ifu_req_rdy,
    input  logic [31:0] ifu_req_addr,
    output logic        ifu_resp_vld,
    input  logic        ifu_resp_rdy,
    output logic [31:0] ifu_resp_rdata,
    input  logic        lsu_req_vld,
    output logic        lsu_req_rdy,
    input  logic        lsu_req_wen,
    input  logic [2:0]  lsu_req_rwtyp,
    input  logic [31:0] lsu_req_addr,
    input  logic [31:0] lsu_req_wdata,
    output logic        lsu_resp_vld,
    input  logic        lsu_resp_rdy,
    output logic [31:0] lsu_resp_rdata,
    output logic        bus_req_vld,
    input  logic        bus_req_rdy,
    output logic        bus_req_wen,
    output logic [2:0]  bus_req_rwtyp,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_resp_vld,
    output logic        bus_resp_rdy,
    input  logic [31:0] bus_resp_rdata
);

    localparam int PW = $clog2(OUTST_DEPTH);
    localparam int CW = $clog2(OUTST_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_HOLD_IFU = 2'd1,
        ST_HOLD_LSU = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [OUTST_DEPTH-1:0] owner_q;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic [SW-1:0]          starve_left;

    logic fifo_full, fifo_empty, head_lsu, ifu_elig, lsu_elig, starved;
    logic grant_any, grant_lsu;
    logic ifu_xfer, lsu_xfer, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTST_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_full  = (count == CW'(OUTST_DEPTH));
    assign fifo_empty = (count == '0);
    assign head_lsu   = owner_q[rd_ptr];
    // The starvation timer counts down from STARVE_LIMIT; zero means the IFU has waited long enough.
    assign starved    = (starve_left == '0);

    // Reads need a free owner slot; stores are posted and never wait on the FIFO.
    assign ifu_elig = ifu_req_vld && !fifo_full;
    assign lsu_elig = lsu_req_vld && (lsu_req_wen || !fifo_full);

    // Grant selection, request mux, and lock decision.
    always_comb begin
        state_nxt     = ST_FREE;
        grant_any     = 1'b0;
        grant_lsu     = 1'b0;
        bus_req_vld   = 1'b0;
        bus_req_wen   = 1'b0;
        bus_req_rwtyp = 3'b000;
        bus_req_addr  = 32'h0;
        bus_req_wdata = 32'h0;
        ifu_req_rdy   = 1'b0;
        lsu_req_rdy   = 1'b0;

        case (state)
            ST_HOLD_IFU: grant_any = 1'b1;
            ST_HOLD_LSU: begin
                grant_any = 1'b1;
                grant_lsu = 1'b1;
            end
            default: begin
                if (lsu_elig && !(starved && ifu_elig)) begin
                    grant_any = 1'b1;
                    grant_lsu = 1'b1;
                end else if (ifu_elig) begin
                    grant_any = 1'b1;
                end
            end
        endcase

        if (grant_any) begin
            if (grant_lsu) begin
                bus_req_vld   = lsu_req_vld;
                bus_req_wen   = lsu_req_wen;
                bus_req_rwtyp = lsu_req_rwtyp;
                bus_req_addr  = lsu_req_addr;
                bus_req_wdata = lsu_req_wdata;
                lsu_req_rdy   = bus_req_rdy;
            end else begin
                bus_req_vld   = ifu_req_vld;
                bus_req_rwtyp = 3'b010;
                bus_req_addr  = ifu_req_addr;
                ifu_req_rdy   = bus_req_rdy;
            end
        end

        if (bus_req_vld && !bus_req_rdy)
            state_nxt = grant_lsu ? ST_HOLD_LSU : ST_HOLD_IFU;
    end

    assign ifu_xfer = ifu_req_vld && ifu_req_rdy;
    assign lsu_xfer = lsu_req_vld && lsu_req_rdy;
    assign push     = (ifu_xfer || (lsu_xfer && !lsu_req_wen)) && !fifo_full;
    assign pop      = bus_resp_vld && bus_resp_rdy;

    // Responses follow the FIFO head. A response arriving while the FIFO is empty is stalled.
    assign bus_resp_rdy   = !fifo_empty && (head_lsu ? lsu_resp_rdy : ifu_resp_rdy);
    assign ifu_resp_vld   = !fifo_empty && !head_lsu && bus_resp_vld;
    assign lsu_resp_vld   = !fifo_empty &&  head_lsu && bus_resp_vld;
    assign ifu_resp_rdata = (!fifo_empty && !head_lsu) ? bus_resp_rdata : 32'h0;
    assign lsu_resp_rdata = (!fifo_empty &&  head_lsu) ? bus_resp_rdata : 32'h0;

    // Grant lock register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_FREE;
        else     state <= state_nxt;
    end

    // Starvation timer: reload when the IFU is idle or served; tick on each LSU win over a waiting IFU.
    always_ff @(posedge clk) begin
        if (rst)
            starve_left <= SW'(STARVE_LIMIT);
        else if (!ifu_req_vld || ifu_xfer)
            starve_left <= SW'(STARVE_LIMIT);
        else if (lsu_xfer && !starved)
            starve_left <= starve_left - SW'(1);
    end

    // Owner FIFO: one source bit per accepted read, popped on each accepted response.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                owner_q[wr_ptr] <= lsu_xfer;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/core_bus_arbiter.md
# core_bus_arbiter

Two-master arbiter sharing the core's single memory-bus request/response port between the instruction fetch unit (IFU) and the load/store unit (LSU). It sits between both units and the bus master. Request forwarding is zero-latency with stall-safe grant locking and LSU-first priority plus an IFU anti-starvation counter. An in-order owner FIFO steers each read response back to the unit that issued the read.

## Interface
- OUTST_DEPTH, 4: max outstanding reads (owner FIFO depth, ≥2).
- STARVE_LIMIT, 4: consecutive LSU grants tolerated while IFU waits (≥1).

- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- ifu_req_vld / ifu_req_rdy  in / out  1  IFU read request handshake.
- ifu_req_addr  in  32  fetch address (always read, rwtyp forced 3'b010).
- ifu_resp_vld / ifu_resp_rdy  out / in  1  IFU response handshake.
- ifu_resp_rdata  out  32  fetch data.
- lsu_req_vld / lsu_req_rdy  in / out  1  LSU request handshake.
- lsu_req_wen  in  1  1 = store.
- lsu_req_rwtyp  in  3  access type (func3).
- lsu_req_addr, lsu_req_wdata  in  32  address, store data.
- lsu_resp_vld / lsu_resp_rdy  out / in  1  LSU load response handshake.
- lsu_resp_rdata  out  32  load data.
- bus_req_vld / bus_req_rdy  out / in  1  bus request handshake.
- bus_req_wen  out  1; bus_req_rwtyp  out  3; bus_req_addr, bus_req_wdata  out  32.
- bus_resp_vld / bus_resp_rdy  in / out  1  bus response handshake.
- bus_resp_rdata  in  32  response data.

## Operation
- Transfer = vld && rdy on a channel. Bus returns exactly one response per accepted read, in acceptance order. Stores are posted: no response, no owner entry.
- Grant state: hold_vld, hold_src (0=IFU, 1=LSU). When hold_vld=0: LSU wins if lsu_req_vld, unless starve_cnt == STARVE_LIMIT and ifu_req_vld, then IFU wins. IFU wins if only IFU requests.
- Eligibility: a read (IFU or LSU with wen=0) is blocked while the owner FIFO is full. A blocked LSU read does not stop an IFU read, and vice versa; both are blocked when full. Stores are never blocked by the FIFO.
- bus_req_* = muxed fields of the granted source. bus_req_vld = granted source's vld. For IFU grants: wen=0, rwtyp=3'b010, wdata=0. With no grant, all bus_req_* are 0.
- granted_rdy = bus_req_rdy; the non-granted unit sees rdy=0.
- Lock: if bus_req_vld && !bus_req_rdy, set hold_vld=1 and hold_src=granted source. The grant stays fixed until the transfer completes, then hold_vld clears. Requesters must keep vld and fields stable while stalled.
- starve_cnt (sat. width for STARVE_LIMIT): on an LSU transfer while ifu_req_vld, +1. On an IFU transfer, or !ifu_req_vld, clear to 0.
- Owner FIFO: on each read transfer, push the source bit. Full blocks the push even if a pop occurs the same cycle. Simultaneous push and pop on a non-full FIFO is allowed, with count unchanged.
- Response path: while the FIFO is non-empty, head=0 routes to IFU and head=1 routes to LSU. owner_resp_vld = bus_resp_vld. bus_resp_rdy = owner_resp_rdy. owner_resp_rdata = bus_resp_rdata. The other unit's resp_vld=0. Pop on bus_resp_vld && bus_resp_rdy.
- While the FIFO is empty, bus_resp_rdy=0 and both resp_vld=0. A bus response arriving then is a protocol error: it is stalled, never forwarded.

## Timing
- Request path is combinational: 0-cycle latency from unit to bus. The grant lock and FIFO update on the rising edge.
- Response path is combinational: 0-cycle latency. A read's response may be accepted no earlier than the cycle after its request transfer; FIFO push is visible next cycle.
- Reset (rst=1 at posedge): hold_vld=0, starve_cnt=0, FIFO empty. While requesters and bus inputs are idle, every output is 0.
- Reset mid-operation discards all owner entries and any held grant. The bus master shares rst and drops its in-flight reads. Units must not hold vld through reset.
- Pointers wrap modulo OUTST_DEPTH. The full flag is derived from a count or an extra pointer bit, not from pointer equality alone.

## Test plan
- Both idle then IFU read 0x100 with bus_req_rdy=1 → same-cycle bus_req_vld=1, addr=0x100, rwtyp=3'b010, wen=0, ifu_req_rdy=1. Response 0xDEADBEEF next cycle → ifu_resp_vld=1, lsu_resp_vld=0.
- IFU and LSU both request continuously with rdy=1 and STARVE_LIMIT=4 → grant pattern LSU,LSU,LSU,LSU,IFU, repeating.
- Grant to LSU store 0x200/0x55 with bus_req_rdy=0 for 3 cycles; IFU raises vld in cycle 1 → bus fields stay at the LSU store until accepted, ifu_req_rdy=0 throughout. Store creates no FIFO entry.
- Issue 4 reads alternating IFU/LSU without responses (depth 4) → fifth read is blocked, while an LSU store is still granted. Return 4 responses with LSU resp_rdy=0 on the 2nd → bus_resp_rdy=0 that cycle, then in-order delivery IFU, LSU, IFU, LSU.
- Simultaneous response pop and new read push with 2 outstanding → count stays 2, ordering preserved.
- Assert rst with 3 reads outstanding and a held grant → next cycle FIFO empty, bus_resp_rdy=0, hold cleared, fresh IFU request granted immediately.
